// File: rtl/adc_pair_sequencer.sv
// adc_pair_sequencer
// Front end for the igniter resistance divider. Alternates ADC conversions on
// the capacitor-voltage and igniter-current channels, subtracts per-channel
// zero offsets and emits each pair in sign + inverted-magnitude ADC format.
// Pairs are spaced so the downstream 16-cycle divider is never reloaded
// mid-divide.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   enable              run continuous sampling while high
//   cal_req             pulse: next completed pair becomes the zero offsets
//   cmd_valid/ready     ADC conversion request handshake
//   cmd_channel         channel for the request
//   rsp_valid           single-cycle ADC result strobe
//   rsp_channel         channel of the result
//   rsp_data            raw unsigned 12-bit result
//   valid_out           single-cycle pulse: v_out/i_out updated this cycle
//   v_out, i_out        voltage / current in ADC format (hold between pulses)
//   cal_done            single-cycle pulse: offsets were loaded
//   err                 single-cycle pulse: timeout or channel mismatch
//   busy                high whenever the sequencer is not idle
module adc_pair_sequencer #(
  parameter logic [4:0]  V_CHAN     = 5'd0,
  parameter logic [4:0]  I_CHAN     = 5'd1,
  parameter int unsigned GAP_CYCLES = 16,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cal_req,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [4:0]  cmd_channel,
  input  logic        rsp_valid,
  input  logic [4:0]  rsp_channel,
  input  logic [11:0] rsp_data,
  output logic        valid_out,
  output logic [11:0] v_out,
  output logic [11:0] i_out,
  output logic        cal_done,
  output logic        err,
  output logic        busy
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [9:0]    TMO      = 10'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    REQ_V,
    WAIT_V,
    REQ_I,
    WAIT_I,
    EMIT,
    GAP
  } state_t;

  state_t        state, state_n;
  logic [9:0]    tmo_cnt;
  logic [GW-1:0] gap_cnt;
  logic [11:0]   raw_v, raw_i;
  logic [11:0]   off_v, off_i;
  logic          cal_pending;
  logic          cap_v, cap_i, abort;

  // Offset-corrected value as sign + inverted, clipped 11-bit magnitude.
  function automatic logic [11:0] encode(input logic [11:0] raw,
                                         input logic [11:0] off);
    logic [12:0] d;
    logic [12:0] a;
    logic [10:0] mag;
    d   = {1'b0, raw} - {1'b0, off};
    a   = d[12] ? (13'd0 - d) : d;
    mag = (a > 13'd2047) ? 11'h7FF : a[10:0];
    return {d[12], mag ^ 11'h7FF};
  endfunction

  always_comb begin
    state_n     = state;
    cap_v       = 1'b0;
    cap_i       = 1'b0;
    abort       = 1'b0;
    cmd_valid   = (state == REQ_V) || (state == REQ_I);
    cmd_channel = ((state == REQ_I) || (state == WAIT_I)) ? I_CHAN : V_CHAN;
    busy        = (state != IDLE);
    unique case (state)
      IDLE:   if (enable) state_n = REQ_V;
      REQ_V:  if (cmd_ready) state_n = WAIT_V;
      WAIT_V: begin
        // A matching response in the final timeout cycle still wins.
        if (rsp_valid && (rsp_channel == V_CHAN)) begin
          cap_v   = 1'b1;
          state_n = REQ_I;
        end else if (rsp_valid || (tmo_cnt == TMO)) begin
          abort   = 1'b1;
          state_n = GAP;
        end
      end
      REQ_I:  if (cmd_ready) state_n = WAIT_I;
      WAIT_I: begin
        if (rsp_valid && (rsp_channel == I_CHAN)) begin
          cap_i   = 1'b1;
          state_n = EMIT;
        end else if (rsp_valid || (tmo_cnt == TMO)) begin
          abort   = 1'b1;
          state_n = GAP;
        end
      end
      EMIT:   state_n = GAP;
      GAP:    if (gap_cnt == GAP_LAST) state_n = enable ? REQ_V : IDLE;
      default: state_n = IDLE;
    endcase
    err = abort;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      gap_cnt     <= '0;
      raw_v       <= '0;
      raw_i       <= '0;
      off_v       <= '0;
      off_i       <= '0;
      cal_pending <= 1'b0;
      valid_out   <= 1'b0;
      v_out       <= 12'h7FF;
      i_out       <= 12'h7FF;
      cal_done    <= 1'b0;
    end else begin
      state     <= state_n;
      valid_out <= 1'b0;
      cal_done  <= 1'b0;
      // Counters run only inside their state, so they are zero on entry.
      tmo_cnt   <= ((state == WAIT_V) || (state == WAIT_I)) ? tmo_cnt + 10'd1 : '0;
      gap_cnt   <= (state == GAP) ? gap_cnt + GW'(1) : '0;
      if (cap_v) raw_v <= rsp_data;
      if (cap_i) raw_i <= rsp_data;
      // A request arriving during EMIT survives the clear and hits the next pair.
      cal_pending <= cal_req | (cal_pending & (state != EMIT));
      if (state == EMIT) begin
        if (cal_pending) begin
          off_v    <= raw_v;
          off_i    <= raw_i;
          cal_done <= 1'b1;
        end else begin
          valid_out <= 1'b1;
          v_out     <= encode(raw_v, off_v);
          i_out     <= encode(raw_i, off_i);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_pair_sequencer.sv
// Testbench for adc_pair_sequencer: behavioural ADC with scoreboard.
module tb_adc_pair_sequencer;

  localparam logic [4:0] V_CH = 5'd0;
  localparam logic [4:0] I_CH = 5'd1;
  localparam int GAP = 16;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        cal_req;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [4:0]  cmd_channel;
  logic        rsp_valid;
  logic [4:0]  rsp_channel;
  logic [11:0] rsp_data;
  logic        valid_out;
  logic [11:0] v_out;
  logic [11:0] i_out;
  logic        cal_done;
  logic        err;
  logic        busy;

  adc_pair_sequencer #(
    .V_CHAN(V_CH),
    .I_CHAN(I_CH),
    .GAP_CYCLES(GAP),
    .TIMEOUT(1023)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .cal_req(cal_req),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_channel(cmd_channel),
    .rsp_valid(rsp_valid),
    .rsp_channel(rsp_channel),
    .rsp_data(rsp_data),
    .valid_out(valid_out),
    .v_out(v_out),
    .i_out(i_out),
    .cal_done(cal_done),
    .err(err),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses = 0;
  int errs  = 0;
  int cals  = 0;
  logic [23:0] expq[$];
  int ptimes[$];
  logic [23:0] mon_e;
  logic [11:0] last_v = 12'h7FF;
  logic [11:0] last_i = 12'h7FF;

  // ADC model state
  logic [11:0] adc_v_data = '0;
  logic [11:0] adc_i_data = '0;
  logic [11:0] m_off_v = '0;
  logic [11:0] m_off_i = '0;
  logic [11:0] m_raw_v = '0;
  bit m_cal = 0;
  bit adc_silent_v = 0;
  bit adc_wrong_v = 0;

  function automatic logic [11:0] model_enc(input logic [11:0] raw, input logic [11:0] off);
    int d;
    int m;
    logic [10:0] low;
    d = int'(raw) - int'(off);
    m = (d < 0) ? -d : d;
    if (m > 2047) m = 2047;
    low = 11'(2047 - m);
    return {(d < 0), low};
  endfunction

  // Output monitor: pops expected pair on each valid_out.
  initial forever begin
    @(negedge clk);
    cyc++;
    if (valid_out) begin
      pulses++;
      ptimes.push_back(cyc);
      total++;
      if (expq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid_out: got v=%h i=%h, required no pulse", v_out, i_out);
      end else begin
        mon_e = expq.pop_front();
        if (v_out !== mon_e[23:12]) begin
          bad++;
          $display("FAIL sb_v_out: got %h required %h", v_out, mon_e[23:12]);
        end
        total++;
        if (i_out !== mon_e[11:0]) begin
          bad++;
          $display("FAIL sb_i_out: got %h required %h", i_out, mon_e[11:0]);
        end
        last_v = mon_e[23:12];
        last_i = mon_e[11:0];
      end
    end
    if (err) errs++;
    if (cal_done) cals++;
  end

  // ADC responder: result in the cycle right after the accepted request.
  initial begin
    rsp_valid   = 1'b0;
    rsp_channel = '0;
    rsp_data    = '0;
    forever begin
      bit hs;
      logic [4:0] ch;
      @(negedge clk);
      hs = cmd_valid && cmd_ready;
      ch = cmd_channel;
      @(posedge clk);
      #1;
      rsp_valid = 1'b0;
      if (hs && !reset) begin
        if (ch == V_CH) begin
          if (!adc_silent_v) begin
            rsp_valid   = 1'b1;
            rsp_channel = adc_wrong_v ? I_CH : V_CH;
            rsp_data    = adc_v_data;
            m_raw_v     = adc_v_data;
          end
        end else begin
          rsp_valid   = 1'b1;
          rsp_channel = I_CH;
          rsp_data    = adc_i_data;
          if (m_cal) begin
            m_off_v = m_raw_v;
            m_off_i = adc_i_data;
            m_cal   = 0;
          end else begin
            expq.push_back({model_enc(m_raw_v, m_off_v), model_enc(adc_i_data, m_off_i)});
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge clk);
    #2;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    tick();
    while (busy && n < 200) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle: busy=%b required 0", tag, busy);
    end
  endtask

  task automatic one_pair(input logic [11:0] v, input logic [11:0] i);
    adc_v_data = v;
    adc_i_data = i;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    wait_idle("pair");
  endtask

  task automatic do_cal(input logic [11:0] v, input logic [11:0] i);
    int c0;
    int p0;
    m_cal   = 1;
    cal_req = 1'b1;
    tick();
    cal_req = 1'b0;
    c0 = cals;
    p0 = pulses;
    one_pair(v, i);
    total++;
    if (cals !== c0 + 1) begin
      bad++;
      $display("FAIL cal_done_count: got %0d required %0d", cals - c0, 1);
    end
    total++;
    if (pulses !== p0) begin
      bad++;
      $display("FAIL cal_no_valid: got %0d pulses required 0", pulses - p0);
    end
  endtask

  task automatic test_reset;
    reset   = 1'b1;
    enable  = 1'b0;
    cal_req = 1'b0;
    cmd_ready = 1'b1;
    repeat (3) tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL rst_cmd_valid: got %b required 0", cmd_valid); end
    total++; if (cmd_channel !== V_CH) begin bad++; $display("FAIL rst_cmd_channel: got %h required %h", cmd_channel, V_CH); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rst_valid_out: got %b required 0", valid_out); end
    total++; if (v_out !== 12'h7FF) begin bad++; $display("FAIL rst_v_out: got %h required 7ff", v_out); end
    total++; if (i_out !== 12'h7FF) begin bad++; $display("FAIL rst_i_out: got %h required 7ff", i_out); end
    total++; if (cal_done !== 1'b0) begin bad++; $display("FAIL rst_cal_done: got %b required 0", cal_done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b required 0", err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b required 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int p0 = pulses;
    one_pair(12'h100, 12'h040);
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL basic_pulses: got %0d required 1", pulses - p0); end
    total++; if (v_out !== 12'h6FF) begin bad++; $display("FAIL basic_v: got %h required 6ff", v_out); end
    total++; if (i_out !== 12'h7BF) begin bad++; $display("FAIL basic_i: got %h required 7bf", i_out); end
  endtask

  task automatic test_cal;
    do_cal(12'h800, 12'h800);
    one_pair(12'h7F0, 12'h810);
    total++; if (v_out !== 12'hFEF) begin bad++; $display("FAIL cal_v: got %h required fef", v_out); end
    total++; if (i_out !== 12'h7EF) begin bad++; $display("FAIL cal_i: got %h required 7ef", i_out); end
  endtask

  task automatic test_clip;
    do_cal(12'h000, 12'h000);
    one_pair(12'hFFF, 12'h000);
    total++; if (v_out !== 12'h000) begin bad++; $display("FAIL clip_pos_v: got %h required 000", v_out); end
    total++; if (i_out !== 12'h7FF) begin bad++; $display("FAIL clip_zero_i: got %h required 7ff", i_out); end
    do_cal(12'hFFF, 12'hFFF);
    one_pair(12'h000, 12'hFFF);
    total++; if (v_out !== 12'h800) begin bad++; $display("FAIL clip_neg_v: got %h required 800", v_out); end
    total++; if (i_out !== 12'h7FF) begin bad++; $display("FAIL clip_neg_i: got %h required 7ff", i_out); end
    do_cal(12'h000, 12'h000);
  endtask

  task automatic test_timeout;
    int p0 = pulses;
    int e0 = errs;
    int n;
    int r;
    int e;
    adc_silent_v = 1;
    adc_v_data = 12'h0AA;
    adc_i_data = 12'h055;
    enable = 1'b1;
    n = 0;
    tick();
    while (!cmd_valid && n < 10) begin tick(); n++; end
    r = cyc;
    n = 0;
    while (errs == e0 && n < 1100) begin tick(); n++; end
    e = cyc;
    total++; if (errs !== e0 + 1) begin bad++; $display("FAIL tmo_err: got %0d pulses required 1", errs - e0); end
    total++; if (e - r !== 1024) begin bad++; $display("FAIL tmo_latency: got %0d cycles required 1024", e - r); end
    total++; if (pulses !== p0) begin bad++; $display("FAIL tmo_no_valid: got %0d pulses required 0", pulses - p0); end
    adc_silent_v = 0;
    n = 0;
    while (!cmd_valid && n < 40) begin tick(); n++; end
    total++; if (cyc - e !== GAP + 1) begin bad++; $display("FAIL tmo_restart: got %0d cycles required %0d", cyc - e, GAP + 1); end
    enable = 1'b0;
    wait_idle("tmo");
    total++; if (pulses !== p0 + 1) begin bad++; $display("FAIL tmo_recover: got %0d pulses required 1", pulses - p0); end
  endtask

  task automatic test_wrong_channel;
    int p0 = pulses;
    int e0 = errs;
    logic [11:0] lv;
    logic [11:0] li;
    lv = last_v;
    li = last_i;
    adc_wrong_v = 1;
    one_pair(12'h555, 12'h2AA);
    adc_wrong_v = 0;
    total++; if (errs !== e0 + 1) begin bad++; $display("FAIL wrong_err: got %0d pulses required 1", errs - e0); end
    total++; if (pulses !== p0) begin bad++; $display("FAIL wrong_no_valid: got %0d pulses required 0", pulses - p0); end
    total++; if (v_out !== lv) begin bad++; $display("FAIL wrong_v_hold: got %h required %h", v_out, lv); end
    total++; if (i_out !== li) begin bad++; $display("FAIL wrong_i_hold: got %h required %h", i_out, li); end
  endtask

  task automatic test_back_to_back;
    int p0 = pulses;
    int pd;
    int n = 0;
    int sz;
    adc_v_data = 12'h123;
    adc_i_data = 12'h456;
    enable = 1'b1;
    tick();
    while (pulses < p0 + 4 && n < 200) begin tick(); n++; end
    total++;
    if (pulses < p0 + 4) begin
      bad++;
      $display("FAIL b2b_pulses: got %0d required 4", pulses - p0);
    end else begin
      sz = ptimes.size();
      for (int k = 1; k <= 3; k++) begin
        total++;
        if (ptimes[sz-k] - ptimes[sz-k-1] !== GAP + 5) begin
          bad++;
          $display("FAIL b2b_period: got %0d required %0d", ptimes[sz-k] - ptimes[sz-k-1], GAP + 5);
        end
      end
    end
    n = 0;
    while (!(busy && !cmd_valid && cmd_channel == I_CH) && n < 50) begin tick(); n++; end
    pd = pulses;
    enable = 1'b0;
    wait_idle("b2b");
    total++; if (pulses !== pd + 1) begin bad++; $display("FAIL drop_in_wait_i: got %0d pulses required 1", pulses - pd); end
  endtask

  task automatic test_reset_mid;
    int n = 0;
    adc_v_data = 12'h321;
    adc_i_data = 12'h0AB;
    enable = 1'b1;
    tick();
    while (!(cmd_valid && cmd_channel == I_CH) && n < 20) begin tick(); n++; end
    reset = 1'b1;
    tick();
    total++; if (cmd_valid !== 1'b0) begin bad++; $display("FAIL midrst_cmd_valid: got %b required 0", cmd_valid); end
    total++; if (v_out !== 12'h7FF) begin bad++; $display("FAIL midrst_v: got %h required 7ff", v_out); end
    total++; if (i_out !== 12'h7FF) begin bad++; $display("FAIL midrst_i: got %h required 7ff", i_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b required 0", busy); end
    enable = 1'b0;
    reset  = 1'b0;
    m_off_v = '0;
    m_off_i = '0;
    m_cal   = 0;
    tick();
  endtask

  task automatic test_random_after_reset;
    for (int k = 0; k < 4; k++) begin
      one_pair(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
    end
    total++;
    if (expq.size() !== 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending required 0", expq.size());
    end
  endtask

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    cal_req = 1'b0;
    cmd_ready = 1'b1;
    test_reset();
    test_basic();
    test_cal();
    test_clip();
    test_timeout();
    test_wrong_channel();
    test_back_to_back();
    test_reset_mid();
    test_random_after_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
